// File: rtl/monolith_pkg.sv
// Shared types and constants for the Monolith hash accelerator egress path.
// The optional canonicalization feature is selected with MONOLITH_TX_CANON_EN.
package monolith_pkg;

    localparam int WORDS  = 16;
    localparam int WORD_W = 31;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Mersenne-31 prime; the all-ones word is the non-canonical encoding of zero.
    localparam logic [WORD_W-1:0] P = 31'h7FFFFFFF;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [0:WORDS-1] state_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/monolith_canon.sv
// Combinational canonicalizer for a Mersenne-31 field element.
// Only instantiated when MONOLITH_TX_CANON_EN is defined.
module monolith_canon
    import monolith_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    // P itself is congruent to zero; every other 31-bit value is already reduced.
    assign word_o = (word_i == P) ? '0 : word_i;

endmodule

// File: rtl/monolith_axis_tx.sv
// Egress serializer: captures a full hash state when the core presents it and
// streams it out as one AXI4-Stream frame of WORDS beats, tlast on the final word.
// Build option: define MONOLITH_TX_CANON_EN to canonicalize words mod 2^31-1.
module monolith_axis_tx
    import monolith_pkg::*;
#(
    parameter int TDATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  word_t              state_in [0:WORDS-1],
    input  logic               state_valid,
    output logic               state_ready,
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    tx_state_t          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   idx_inc;
    logic [TDATA_W-1:0] tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               capture;

    word_t buf_q    [0:WORDS-1];
    word_t cap_word [0:WORDS-1];

    // Canonicalization happens on the way into the buffer, so the output path
    // is identical in both builds and latency does not change.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_cap
`ifdef MONOLITH_TX_CANON_EN
            monolith_canon u_canon (
                .word_i (state_in[gi]),
                .word_o (cap_word[gi])
            );
`else
            assign cap_word[gi] = state_in[gi];
`endif
        end
    endgenerate

    assign idx_inc = idx_q + IDX_W'(1);

    // Next-state and next-output logic; the output word register is loaded
    // from the buffer one beat ahead so tdata always comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (state_valid) begin
                    capture  = 1'b1;
                    state_d  = SEND;
                    idx_d    = '0;
                    tdata_d  = TDATA_W'(cap_word[0]);
                    tvalid_d = 1'b1;
                    tlast_d  = (LAST_IDX == '0);
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (tlast_q) begin
                        state_d  = IDLE;
                        idx_d    = '0;
                        tdata_d  = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end else begin
                        idx_d   = idx_inc;
                        tdata_d = TDATA_W'(buf_q[idx_inc]);
                        tlast_d = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers; reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    // Frame buffer owned by the block; written only on the capture cycle.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < WORDS; i++) begin
                buf_q[i] <= cap_word[i];
            end
        end
    end

    assign state_ready   = (state_q == IDLE);
    assign busy          = (state_q == SEND);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: doc/monolith_axis_tx.md
# monolith_axis_tx

Egress serializer for the Monolith hash accelerator. Captures the 16-word, 31-bit permutation state presented by the hash core when it asserts valid, then streams it out word by word on an AXI4-Stream master interface with full tready backpressure, marking the 16th word with tlast. It sits between the hash core's state output and the system DMA/interconnect, and replaces the free-running output counter with a handshaked transmitter.

## Interface
- WORDS, 16, number of state words per frame
- WORD_W, 31, state word width (Mersenne-31 field element)
- TDATA_W, 32, AXI-Stream data width; must be ≥ WORD_W
- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-low; 0 at a clk edge resets the block
- state_in  input  WORDS×WORD_W  unpacked array [0:WORDS-1] of hash state words
- state_valid  input  1  state_in holds a complete result
- state_ready  output  1  block can accept a new state
- m_axis_tdata  output  TDATA_W  current word, zero-extended
- m_axis_tvalid  output  1  tdata is valid
- m_axis_tready  input  1  downstream accepts the beat
- m_axis_tlast  output  1  last word of frame
- busy  output  1  frame in progress (state == SEND)

## Operation
- Two-state FSM: IDLE, SEND.
- IDLE: state_ready=1, m_axis_tvalid=0. When state_valid=1, copy all WORDS words into an internal buffer, set index to 0, and go to SEND.
- SEND: state_ready=0, m_axis_tvalid=1, m_axis_tdata={(TDATA_W-WORD_W)'b0, buf[index]}, m_axis_tlast=(index==WORDS-1).
- A beat completes on tvalid && tready: index increments. If the completed beat had tlast=1, the FSM returns to IDLE.
- tvalid && !tready: tdata, tlast and index hold. tvalid never deasserts before the beat completes.
- state_valid during SEND is ignored. The producer must hold state_valid until it sees state_ready.
- The buffer is owned by the block, so state_in may change any time after capture.
- Index is ceil(log2(WORDS)) bits wide and never wraps past WORDS-1.

## Timing
- Reset values: state=IDLE, index=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, state_ready=1 (the value in IDLE).
- Capture edge N → first beat has tvalid=1 at cycle N+1.
- With tready held at 1: beats occur at cycles N+1..N+WORDS, and tlast=1 at N+WORDS. The block is in IDLE, with state_ready=1, at N+WORDS+1.
- Minimum frame period is WORDS+1 cycles. No overlap between capture and the final beat.
- state_ready is a registered function of the FSM state. There is no combinational path from tready to state_ready.
- Reset mid-frame: the frame is dropped and tvalid=0 from the next cycle. A partial frame without tlast is acceptable only across reset.
- tdata, tvalid and tlast come directly from registers. buf[index] is read through a mux fed by the index register, with no input-to-output combinational path.

## Configuration
- MONOLITH_TX_CANON_EN defined: each word is canonicalized mod p = 2^31−1 on output. 31'h7FFFFFFF is emitted as 0, and all other values pass through unchanged.
- Undefined: words are emitted raw, bit-exact from state_in.
- Latency and handshake are identical in both builds.

## Structure
- Shared package monolith_pkg holds:
  - WORD_W, WORDS and the prime P=31'h7FFFFFFF
  - typedef word_t (logic [WORD_W-1:0])
  - typedef state_t (word_t [0:WORDS-1])
  - typedef enum tx_state_t {IDLE, SEND}
- One combinational sub-module, monolith_canon (word_t in → word_t out), instantiated only under MONOLITH_TX_CANON_EN.

## Test plan
- Reset then state_in[i]=i+1, state_valid for 1 cycle, tready=1 → 16 beats with tdata 1..16 on consecutive cycles, tlast only on tdata=16, state_ready back to 1 one cycle after.
- Same frame with tready toggling 1,0,1,0… → data sequence 1..16 unchanged; tdata/tlast stable on every stall cycle; 31 cycles of tvalid.
- state_in[3]=31'h7FFFFFFF, state_in[4]=31'h7FFFFFFE → with MONOLITH_TX_CANON_EN beat 3 = 0 and beat 4 = 32'h7FFFFFFE; without it, beat 3 = 32'h7FFFFFFF.
- Assert state_valid with a new pattern during beat 5 of frame A → frame A completes unaltered; the new frame is captured only after returning to IDLE.
- reset=0 during beat 8, then reset=1 → tvalid=0, busy=0, state_ready=1 the next cycle; the following frame starts at word 0.
- Back-to-back state_valid held high, tready=1 → frames separated by exactly one idle cycle; period = 17 cycles.
